// File: rtl/sr_latch_arb_pkg.sv
// Shared definitions for the SR latch write controller: FSM encodings,
// default geometry and the pulse counter width.
package sr_latch_arb_pkg;

   localparam logic [1:0] SR_ST_IDLE  = 2'd0;
   localparam logic [1:0] SR_ST_SETUP = 2'd1;
   localparam logic [1:0] SR_ST_PULSE = 2'd2;
   localparam logic [1:0] SR_ST_HOLD  = 2'd3;

   localparam int SR_DEF_WIDTH     = 8;
   localparam int SR_DEF_ADDR_W    = 3;
   localparam int SR_DEF_EN_CYCLES = 2;
   localparam int SR_CNT_W         = 4;

   typedef logic [SR_CNT_W-1:0] sr_cnt_t;

endpackage

// File: rtl/sr_latch_arb_rr_arb2.sv
// Two-input round-robin arbiter; the pointer names the requester that wins a tie
// and moves to the loser whenever Advance confirms a grant.
module rr_arb2 (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       Req0,
   input  logic       Req1,
   input  logic       Advance,
   output logic [1:0] Win
);

   logic ptr_q;
   logic ptr_d;

   always_comb begin
      Win = 2'b00;
      if (Req0 && Req1) begin
         Win = ptr_q ? 2'b10 : 2'b01;
      end else if (Req0) begin
         Win = 2'b01;
      end else if (Req1) begin
         Win = 2'b10;
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (Advance) begin
         ptr_d = Win[0];
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/sr_latch_arb.sv
// Write controller for a bank of gated SR latches: arbitrates two requesters and
// sequences SETUP/PULSE/HOLD. Optional macro SR_LATCH_ARB_CLEAR_EN adds a bulk Clr.
module sr_latch_arb
   import sr_latch_arb_pkg::*;
#(
   parameter int WIDTH     = SR_DEF_WIDTH,
   parameter int ADDR_W    = SR_DEF_ADDR_W,
   parameter int EN_CYCLES = SR_DEF_EN_CYCLES
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Req0,
   input  logic              Req1,
   input  logic [ADDR_W-1:0] Addr0,
   input  logic [ADDR_W-1:0] Addr1,
   input  logic              Val0,
   input  logic              Val1,
`ifdef SR_LATCH_ARB_CLEAR_EN
   input  logic              Clr,
`endif
   output logic              Gnt0,
   output logic              Gnt1,
   output logic              S,
   output logic              R,
   output logic [WIDTH-1:0]  En,
   output logic              Busy,
   output logic              Done,
   output logic              Err,
   output logic [1:0]        State_dbg
);

   // Handshake: a requester raises Req with Addr/Val stable and holds it until it
   // sees its one-cycle Gnt (the cycle after acceptance), then drops Req at the
   // following edge; the loser keeps Req high and is served by the next acceptance.

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   sr_cnt_t           cnt_q, cnt_d;
   logic              clr_q, clr_d;
   logic              s_q, s_d, r_q, r_d;
   logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic              done_q, done_d, err_q, err_d;
   logic              busy_q, busy_d;
   logic [WIDTH-1:0]  en_q, en_d, en_dec;
   logic              addr_oor;
   logic              advance;
   logic [1:0]        win;
   logic              clr_req;

`ifdef SR_LATCH_ARB_CLEAR_EN
   assign clr_req = Clr;
`else
   assign clr_req = 1'b0;
`endif

   rr_arb2 u_arb (
      .Clk     (Clk),
      .Rst     (Rst),
      .Req0    (Req0),
      .Req1    (Req1),
      .Advance (advance),
      .Win     (win)
   );

   assign addr_oor = (int'(addr_q) >= WIDTH);

   always_comb begin
      en_dec = '0;
      if (clr_q) begin
         en_dec = '1;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (addr_q == ADDR_W'(i)) en_dec[i] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      clr_d   = clr_q;
      s_d     = s_q;
      r_d     = r_q;
      gnt0_d  = 1'b0;
      gnt1_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      advance = 1'b0;
      case (state_q)
         SR_ST_IDLE: begin
            if (clr_req) begin
               state_d = SR_ST_SETUP;
               clr_d   = 1'b1;
               s_d     = 1'b0;
               r_d     = 1'b1;
            end else if (Req0 || Req1) begin
               state_d = SR_ST_SETUP;
               clr_d   = 1'b0;
               advance = 1'b1;
               if (win[0]) begin
                  addr_d = Addr0;
                  s_d    = Val0;
                  r_d    = ~Val0;
                  gnt0_d = 1'b1;
               end else begin
                  addr_d = Addr1;
                  s_d    = Val1;
                  r_d    = ~Val1;
                  gnt1_d = 1'b1;
               end
            end
         end
         SR_ST_SETUP: begin
            state_d = SR_ST_PULSE;
            cnt_d   = SR_CNT_W'(EN_CYCLES - 1);
         end
         SR_ST_PULSE: begin
            if (cnt_q == '0) begin
               state_d = SR_ST_HOLD;
               done_d  = 1'b1;
               err_d   = ~clr_q & addr_oor;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            // S/R are released only once En has been low for a full cycle.
            state_d = SR_ST_IDLE;
            s_d     = 1'b0;
            r_d     = 1'b0;
         end
      endcase
      en_d   = (state_d == SR_ST_PULSE) ? en_dec : '0;
      busy_d = (state_d != SR_ST_IDLE);
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q <= SR_ST_IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         clr_q   <= 1'b0;
         s_q     <= 1'b0;
         r_q     <= 1'b0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         en_q    <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         clr_q   <= clr_d;
         s_q     <= s_d;
         r_q     <= r_d;
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
         done_q  <= done_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         en_q    <= en_d;
      end
   end

   assign Gnt0      = gnt0_q;
   assign Gnt1      = gnt1_q;
   assign S         = s_q;
   assign R         = r_q;
   assign En        = en_q;
   assign Busy      = busy_q;
   assign Done      = done_q;
   assign Err       = err_q;
   assign State_dbg = state_q;

endmodule

// File: tb/tb_sr_latch_arb.sv
// Directed bench for sr_latch_arb: an 8-cell instance with a behavioural latch bank,
// plus a 5-cell instance for the out-of-range address case.
module tb_sr_latch_arb;

   logic       clk = 1'b0;
   logic       rst = 1'b0;

   logic       a_req0 = 0, a_req1 = 0, a_val0 = 0, a_val1 = 0, a_clr = 0;
   logic [2:0] a_addr0 = 0, a_addr1 = 0;
   logic       a_gnt0, a_gnt1, a_s, a_r, a_busy, a_done, a_err;
   logic [7:0] a_en;
   logic [1:0] a_state;

   logic       b_req0 = 0, b_req1 = 0, b_val0 = 0, b_val1 = 0, b_clr = 0;
   logic [2:0] b_addr0 = 0, b_addr1 = 0;
   logic       b_gnt0, b_gnt1, b_s, b_r, b_busy, b_done, b_err;
   logic [4:0] b_en;
   logic [1:0] b_state;

   int         n_checks = 0;
   int         n_errors = 0;
   int         viol = 0;
   logic [7:0] q = 8'h00;
   logic       s_prev = 0, r_prev = 0;
   logic [7:0] en_prev = 0;

   always #5 clk = ~clk;

   sr_latch_arb #(.WIDTH(8), .ADDR_W(3), .EN_CYCLES(2)) dut_a (
      .Clk(clk), .Rst(rst), .Req0(a_req0), .Req1(a_req1),
      .Addr0(a_addr0), .Addr1(a_addr1), .Val0(a_val0), .Val1(a_val1),
`ifdef SR_LATCH_ARB_CLEAR_EN
      .Clr(a_clr),
`endif
      .Gnt0(a_gnt0), .Gnt1(a_gnt1), .S(a_s), .R(a_r), .En(a_en),
      .Busy(a_busy), .Done(a_done), .Err(a_err), .State_dbg(a_state)
   );

   sr_latch_arb #(.WIDTH(5), .ADDR_W(3), .EN_CYCLES(2)) dut_b (
      .Clk(clk), .Rst(rst), .Req0(b_req0), .Req1(b_req1),
      .Addr0(b_addr0), .Addr1(b_addr1), .Val0(b_val0), .Val1(b_val1),
`ifdef SR_LATCH_ARB_CLEAR_EN
      .Clr(b_clr),
`endif
      .Gnt0(b_gnt0), .Gnt1(b_gnt1), .S(b_s), .R(b_r), .En(b_en),
      .Busy(b_busy), .Done(b_done), .Err(b_err), .State_dbg(b_state)
   );

   // Latch bank model plus invariant monitor, sampled mid-cycle.
   always @(negedge clk) begin
      for (int i = 0; i < 8; i++) begin
         if (a_en[i] && a_s) q[i] <= 1'b1;
         else if (a_en[i] && a_r) q[i] <= 1'b0;
      end
      if (!rst) begin
         if (a_s && a_r) viol <= viol + 1;
         else if (!$onehot0(a_en)) viol <= viol + 1;
         else if ((a_en != 0) && (en_prev != 0) && ({a_s, a_r} != {s_prev, r_prev})) viol <= viol + 1;
      end
      s_prev  <= a_s;
      r_prev  <= a_r;
      en_prev <= a_en;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int         ng;
      logic [3:0] rr_seq;
      logic [4:0] en_seen;
      logic       done_seen;

      // Reset state
      #2 rst = 1'b1;
      #1;
      chk("rst_en", 32'(a_en), 32'h0);
      chk("rst_outs", 32'({a_s, a_r, a_busy, a_gnt0, a_gnt1, a_done, a_err}), 32'h0);
      chk("rst_state", 32'(a_state), 32'd0);
      chk("rst_b", 32'({b_en, b_busy}), 32'h0);
      step(); step();
      rst = 1'b0;
      step();

      // Single write: Addr0=3, Val0=1
      a_req0 = 1; a_addr0 = 3'd3; a_val0 = 1;
      step();
      chk("t1_gnt", 32'({a_gnt0, a_gnt1}), 32'b10);
      chk("t1_sr_setup", 32'({a_s, a_r}), 32'b10);
      chk("t1_en_setup", 32'(a_en), 32'h00);
      chk("t1_busy", 32'(a_busy), 32'd1);
      chk("t1_state", 32'(a_state), 32'd1);
      a_req0 = 0;
      step();
      chk("t1_en_c2", 32'(a_en), 32'h08);
      chk("t1_gnt_drop", 32'(a_gnt0), 32'd0);
      step();
      chk("t1_en_c3", 32'(a_en), 32'h08);
      chk("t1_nodone_c3", 32'(a_done), 32'd0);
      step();
      chk("t1_en_hold", 32'(a_en), 32'h00);
      chk("t1_done_err", 32'({a_done, a_err}), 32'b10);
      chk("t1_sr_hold", 32'({a_s, a_r}), 32'b10);
      step();
      chk("t1_idle", 32'({a_s, a_r, a_busy, a_done}), 32'h0);
      chk("t1_q3", 32'(q[3]), 32'd1);

      // Simultaneous requests after reset
      rst = 1'b1; step(); rst = 1'b0; step();
      a_req0 = 1; a_addr0 = 3'd1; a_val0 = 0;
      a_req1 = 1; a_addr1 = 3'd6; a_val1 = 1;
      step();
      chk("t2_gnt0", 32'({a_gnt0, a_gnt1}), 32'b10);
      chk("t2_sr0", 32'({a_s, a_r}), 32'b01);
      a_req0 = 0;
      step();
      chk("t2_en0", 32'(a_en), 32'h02);
      step(); step();
      chk("t2_done0", 32'(a_done), 32'd1);
      step();
      chk("t2_idle_gap", 32'({a_busy, a_gnt1}), 32'b00);
      step();
      chk("t2_gnt1", 32'({a_gnt0, a_gnt1}), 32'b01);
      chk("t2_sr1", 32'({a_s, a_r}), 32'b10);
      a_req1 = 0;
      step();
      chk("t2_en1", 32'(a_en), 32'h40);
      chk("t2_s1", 32'({a_s, a_r}), 32'b10);
      step(); step();
      chk("t2_done1", 32'(a_done), 32'd1);
      step();
      chk("t2_idle", 32'(a_busy), 32'd0);
      chk("t2_q", 32'({q[6], q[1]}), 32'b10);

      // Round-robin with both requests held
      a_req0 = 1; a_addr0 = 3'd0; a_val0 = 1;
      a_req1 = 1; a_addr1 = 3'd7; a_val1 = 1;
      ng = 0; rr_seq = 4'b0000;
      for (int i = 0; i < 30 && ng < 4; i++) begin
         step();
         if (a_gnt0 || a_gnt1) begin
            rr_seq = {rr_seq[2:0], a_gnt1};
            ng++;
            if (ng == 4) begin
               a_req0 = 0;
               a_req1 = 0;
            end
         end
      end
      chk("rr_count", 32'(ng), 32'd4);
      chk("rr_seq", 32'(rr_seq), 32'b0101);
      repeat (6) step();
      chk("rr_idle", 32'(a_busy), 32'd0);
      chk("rr_q", 32'({q[7], q[0]}), 32'b11);

      // Out-of-range address on the 5-cell instance
      b_req0 = 1; b_addr0 = 3'd5; b_val0 = 1;
      en_seen = '0;
      step();
      chk("oor_gnt", 32'(b_gnt0), 32'd1);
      b_req0 = 0;
      en_seen |= b_en;
      step(); en_seen |= b_en;
      step(); en_seen |= b_en;
      step(); en_seen |= b_en;
      chk("oor_done_err", 32'({b_done, b_err}), 32'b11);
      chk("oor_en", 32'(en_seen), 32'h0);
      step();
      chk("oor_idle", 32'({b_busy, b_done, b_err}), 32'b000);

      // Reset mid-pulse, then a normal write
      a_req0 = 1; a_addr0 = 3'd2; a_val0 = 1;
      step();
      a_req0 = 0;
      step();
      chk("mp_en", 32'(a_en), 32'h04);
      #3 rst = 1'b1;
      #1;
      chk("mp_async_en", 32'(a_en), 32'h00);
      chk("mp_async_srb", 32'({a_s, a_r, a_busy}), 32'b000);
      #1 rst = 1'b0;
      done_seen = 1'b0;
      repeat (4) begin
         step();
         done_seen |= a_done;
      end
      chk("mp_no_done", 32'(done_seen), 32'd0);
      a_req1 = 1; a_addr1 = 3'd4; a_val1 = 0;
      step();
      chk("mp_gnt1", 32'({a_gnt0, a_gnt1}), 32'b01);
      chk("mp_sr", 32'({a_s, a_r}), 32'b01);
      a_req1 = 0;
      step();
      chk("mp_en_next", 32'(a_en), 32'h10);
      step(); step();
      chk("mp_done_next", 32'({a_done, a_err}), 32'b10);
      step();
      chk("mp_idle", 32'(a_busy), 32'd0);

`ifdef SR_LATCH_ARB_CLEAR_EN
      // Clear beats a pending request
      a_clr = 1; a_req1 = 1; a_addr1 = 3'd5; a_val1 = 1;
      step();
      a_clr = 0;
      chk("clr_nognt", 32'({a_gnt0, a_gnt1}), 32'b00);
      chk("clr_sr", 32'({a_s, a_r}), 32'b01);
      step();
      chk("clr_en", 32'(a_en), 32'hff);
      step(); step();
      chk("clr_done", 32'({a_done, a_err}), 32'b10);
      step();
      chk("clr_q", 32'(q), 32'h00);
      step();
      chk("clr_then_gnt1", 32'(a_gnt1), 32'd1);
      a_req1 = 0;
      repeat (5) step();
      chk("clr_q5", 32'(q[5]), 32'd1);
`endif

      chk("invariants", 32'(viol), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
